// File: rtl/mult_rb_pkg.sv
// Shared types and helpers for the multiplier result buffer.
package mult_rb_pkg;

   localparam int MULT_RB_DEPTH = 4;
   localparam int PREG_BITS     = 6;
   localparam int BR_BITS       = 4;
   localparam int PRODUCT_BITS  = 64;

   typedef enum logic [1:0] {
      NOTHING = 2'd0,
      CLEAR   = 2'd1,
      SQUASH  = 2'd2
   } br_task_e;

   typedef struct packed {
      logic                    live;
      logic [PRODUCT_BITS-1:0] product;
      logic [PREG_BITS-1:0]    tag;
      logic [BR_BITS-1:0]      br_mask;
   } mult_rb_entry_t;

   function automatic logic br_hit(input logic [BR_BITS-1:0] mask,
                                   input logic [BR_BITS-1:0] b_id);
      return |(mask & b_id);
   endfunction

endpackage

// File: rtl/mult_rb_ptr.sv
// Wrap-around circular-buffer pointer; advances by one slot when inc is high.
module mult_rb_ptr #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     inc,
   output logic [$clog2(DEPTH)-1:0] ptr
);

   logic [$clog2(DEPTH)-1:0] ptr_reg;

   // DEPTH is a power of two, so natural overflow gives the modulo wrap.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_reg <= '0;
      end else if (inc) begin
         ptr_reg <= ptr_reg + 1'b1;
      end
   end

   assign ptr = ptr_reg;

endmodule

// File: rtl/mult_result_buffer.sv
// In-order result queue between the multiplier and the CDB, with branch clear/squash.
// Optional same-cycle forwarding when empty is enabled by defining MULT_RB_BYPASS_EN.
module mult_result_buffer
   import mult_rb_pkg::*;
#(
   parameter int DEPTH = MULT_RB_DEPTH
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       in_valid,
   input  logic [PRODUCT_BITS-1:0]    in_product,
   input  logic [PREG_BITS-1:0]       in_tag,
   input  logic [BR_BITS-1:0]         in_br_mask,
   input  logic [1:0]                 rem_br_task,
   input  logic [BR_BITS-1:0]         rem_b_id,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [PRODUCT_BITS-1:0]    out_product,
   output logic [PREG_BITS-1:0]       out_tag,
   output logic                       stall_out,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int CNT_BITS = PTR_BITS + 1;

   mult_rb_entry_t         entry_q [DEPTH];
   mult_rb_entry_t         head_entry;
   logic [PTR_BITS-1:0]    head;
   logic [PTR_BITS-1:0]    tail;
   logic [CNT_BITS-1:0]    count_reg;
   logic [CNT_BITS-1:0]    count_next;
   logic [BR_BITS-1:0]     in_mask_clr;
   logic                   is_clear;
   logic                   is_squash;
   logic                   in_killed;
   logic                   occupied;
   logic                   head_out_valid;
   logic                   head_dead;
   logic                   head_leaves;
   logic                   bypass;
   logic                   push;

   assign is_clear    = (rem_br_task == CLEAR);
   assign is_squash   = (rem_br_task == SQUASH);
   assign in_mask_clr = is_clear ? (in_br_mask & ~rem_b_id) : in_br_mask;
   assign in_killed   = is_squash && br_hit(in_br_mask, rem_b_id);

   assign head_entry     = entry_q[head];
   assign occupied       = (count_reg != '0);
   // A head being squashed this very cycle must not reach the CDB.
   assign head_out_valid = occupied && head_entry.live &&
                           !(is_squash && br_hit(head_entry.br_mask, rem_b_id));
   assign head_dead      = occupied && !head_entry.live;
   assign head_leaves    = (head_out_valid && out_ready) || head_dead;
   assign stall_out      = (count_reg == CNT_BITS'(DEPTH)) && !head_leaves;

`ifdef MULT_RB_BYPASS_EN
   assign bypass = !occupied && in_valid && !in_killed && out_ready;
`else
   assign bypass = 1'b0;
`endif

   assign push = in_valid && !stall_out && !in_killed && !bypass;

   assign out_valid   = head_out_valid || bypass;
   assign out_product = bypass ? in_product : head_entry.product;
   assign out_tag     = bypass ? in_tag     : head_entry.tag;

   mult_rb_ptr #(.DEPTH(DEPTH)) u_head_ptr (
      .clock (clock),
      .reset (reset),
      .inc   (head_leaves),
      .ptr   (head)
   );

   mult_rb_ptr #(.DEPTH(DEPTH)) u_tail_ptr (
      .clock (clock),
      .reset (reset),
      .inc   (push),
      .ptr   (tail)
   );

   always_comb begin
      count_next = count_reg;
      if (push && !head_leaves) begin
         count_next = count_reg + 1'b1;
      end else if (!push && head_leaves) begin
         count_next = count_reg - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign count = count_reg;

   // Each slot either takes the new push or applies the branch task to itself.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      mult_rb_entry_t slot_reg;

      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            slot_reg <= '0;
         end else if (push && (tail == PTR_BITS'(gi))) begin
            slot_reg.live    <= 1'b1;
            slot_reg.product <= in_product;
            slot_reg.tag     <= in_tag;
            slot_reg.br_mask <= in_mask_clr;
         end else begin
            if (is_clear) begin
               slot_reg.br_mask <= slot_reg.br_mask & ~rem_b_id;
            end
            if (is_squash && br_hit(slot_reg.br_mask, rem_b_id)) begin
               slot_reg.live <= 1'b0;
            end
         end
      end

      assign entry_q[gi] = slot_reg;
   end

endmodule

// File: tb/tb_mult_result_buffer.sv
// Directed self-checking bench for mult_result_buffer (both MULT_RB_BYPASS_EN builds).
module tb_mult_result_buffer;
   import mult_rb_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid;
   logic [63:0] in_product;
   logic [5:0]  in_tag;
   logic [3:0]  in_br_mask;
   logic [1:0]  rem_br_task;
   logic [3:0]  rem_b_id;
   logic        out_ready;
   logic        out_valid;
   logic [63:0] out_product;
   logic [5:0]  out_tag;
   logic        stall_out;
   logic [2:0]  count;

   int total = 0;
   int bad   = 0;

   mult_result_buffer #(.DEPTH(4)) dut (
      .clock       (clock),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_product  (in_product),
      .in_tag      (in_tag),
      .in_br_mask  (in_br_mask),
      .rem_br_task (rem_br_task),
      .rem_b_id    (rem_b_id),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_product (out_product),
      .out_tag     (out_tag),
      .stall_out   (stall_out),
      .count       (count)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      in_valid    = 1'b0;
      in_product  = '0;
      in_tag      = '0;
      in_br_mask  = '0;
      rem_br_task = 2'd0;
      rem_b_id    = '0;
   endtask

   task automatic drive_push(input logic [5:0] tag, input logic [63:0] prod, input logic [3:0] mask);
      in_valid   = 1'b1;
      in_tag     = tag;
      in_product = prod;
      in_br_mask = mask;
      $display("push tag=%0d product=%h mask=%b", tag, prod, mask);
   endtask

   task automatic test_reset();
      idle();
      out_ready = 1'b0;
      reset = 1'b0;
      tick();
      tick();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_out); end
      reset = 1'b1;
      tick();
      for (int i = 1; i <= 3; i++) begin
         drive_push(6'(i), 64'(i), 4'b0000);
         tick();
      end
      idle();
      #1;
      total++; if (count !== 3'd3) begin bad++; $display("FAIL prereset_count got=%0d want=3", count); end
      reset = 1'b0;
      #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL midreset_count got=%0d want=0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
      total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL midreset_stall got=%b want=0", stall_out); end
      tick();
      reset = 1'b1;
      tick();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL postreset_count got=%0d want=0", count); end
      $display("reset test complete");
   endtask

   task automatic test_single();
      out_ready = 1'b0;
      drive_push(6'd5, 64'h0000_0000_0000_0042, 4'b0000);
      tick();
      idle();
      #1;
      total++; if ({out_valid, out_tag} !== {1'b1, 6'd5}) begin bad++; $display("FAIL single_head got=v%b tag%0d want=v1 tag5", out_valid, out_tag); end
      total++; if (out_product !== 64'h42) begin bad++; $display("FAIL single_product got=%h want=42", out_product); end
      total++; if (count !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
      out_ready = 1'b1;
      tick();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL single_drain_count got=%0d want=0", count); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid got=%b want=0", out_valid); end
      out_ready = 1'b0;
   endtask

   task automatic test_full();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive_push(6'(i), 64'h100 + 64'(i), 4'b0000);
         tick();
      end
      drive_push(6'd5, 64'h105, 4'b0000);
      #1;
      total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", count); end
      total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL full_stall got=%b want=1", stall_out); end
      tick();
      total++; if (count !== 3'd4) begin bad++; $display("FAIL full_blocked_count got=%0d want=4", count); end
      out_ready = 1'b1;
      #1;
      total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL full_pop_stall got=%b want=0", stall_out); end
      tick();
      in_valid = 1'b0;
      #1;
      total++; if (count !== 3'd4) begin bad++; $display("FAIL full_swap_count got=%0d want=4", count); end
      for (int i = 2; i <= 5; i++) begin
         total++;
         if ({out_valid, out_tag, out_product} !== {1'b1, 6'(i), 64'h100 + 64'(i)}) begin
            bad++;
            $display("FAIL full_order got=v%b tag%0d prod%h want=v1 tag%0d", out_valid, out_tag, out_product, i);
         end
         tick();
      end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL full_drain_count got=%0d want=0", count); end
      out_ready = 1'b0;
   endtask

   task automatic test_squash();
      int         n_out = 0;
      logic [5:0] seen_tag = '0;
      out_ready = 1'b0;
      drive_push(6'd1, 64'h11, 4'b0001); tick();
      drive_push(6'd2, 64'h22, 4'b0010); tick();
      drive_push(6'd3, 64'h33, 4'b0001); tick();
      idle();
      rem_br_task = 2'd2;
      rem_b_id    = 4'b0001;
      out_ready   = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL squash_head_valid got=%b want=0", out_valid); end
      tick();
      rem_br_task = 2'd0;
      rem_b_id    = '0;
      for (int k = 0; k < 3; k++) begin
         #1;
         if (out_valid === 1'b1) begin
            n_out++;
            seen_tag = out_tag;
         end
         tick();
      end
      total++; if (count !== 3'd0) begin bad++; $display("FAIL squash_drain_count got=%0d want=0", count); end
      total++; if (n_out != 1) begin bad++; $display("FAIL squash_outputs got=%0d want=1", n_out); end
      total++; if (seen_tag !== 6'd2) begin bad++; $display("FAIL squash_survivor got=%0d want=2", seen_tag); end
      out_ready = 1'b0;
   endtask

   task automatic test_clear_incoming();
      out_ready = 1'b0;
      drive_push(6'd9, 64'h99, 4'b0100);
      rem_br_task = 2'd1;
      rem_b_id    = 4'b0100;
      tick();
      idle();
      rem_br_task = 2'd2;
      rem_b_id    = 4'b0100;
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clear_in_survives got=%b want=1", out_valid); end
      tick();
      idle();
      #1;
      total++; if ({count, out_valid, out_tag} !== {3'd1, 1'b1, 6'd9}) begin bad++; $display("FAIL clear_in_held got=cnt%0d v%b tag%0d want=cnt1 v1 tag9", count, out_valid, out_tag); end
      out_ready = 1'b1;
      tick();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL clear_in_drain got=%0d want=0", count); end
      out_ready = 1'b0;
   endtask

   task automatic test_squash_incoming();
      out_ready = 1'b0;
      drive_push(6'd10, 64'hA, 4'b0000);
      tick();
      drive_push(6'd11, 64'hB, 4'b1000);
      rem_br_task = 2'd2;
      rem_b_id    = 4'b1000;
      tick();
      idle();
      #1;
      total++; if ({count, out_tag} !== {3'd1, 6'd10}) begin bad++; $display("FAIL squash_in_count got=cnt%0d tag%0d want=cnt1 tag10", count, out_tag); end
      out_ready = 1'b1;
      tick();
      total++; if ({count, out_valid} !== {3'd0, 1'b0}) begin bad++; $display("FAIL squash_in_drain got=cnt%0d v%b want=cnt0 v0", count, out_valid); end
      drive_push(6'd12, 64'hC, 4'b1000);
      rem_br_task = 2'd2;
      rem_b_id    = 4'b1000;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL squash_in_empty_valid got=%b want=0", out_valid); end
      tick();
      idle();
      #1;
      total++; if (count !== 3'd0) begin bad++; $display("FAIL squash_in_empty_count got=%0d want=0", count); end
      out_ready = 1'b0;
   endtask

   task automatic test_latency();
      out_ready = 1'b1;
      drive_push(6'd7, 64'h77, 4'b0000);
      #1;
`ifdef MULT_RB_BYPASS_EN
      total++; if ({out_valid, out_tag, out_product} !== {1'b1, 6'd7, 64'h77}) begin bad++; $display("FAIL bypass_out got=v%b tag%0d prod%h want=v1 tag7 prod77", out_valid, out_tag, out_product); end
      tick();
      idle();
      #1;
      total++; if ({count, out_valid} !== {3'd0, 1'b0}) begin bad++; $display("FAIL bypass_count got=cnt%0d v%b want=cnt0 v0", count, out_valid); end
`else
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL latency_same_cycle got=%b want=0", out_valid); end
      tick();
      idle();
      #1;
      total++; if ({count, out_valid, out_tag} !== {3'd1, 1'b1, 6'd7}) begin bad++; $display("FAIL latency_next got=cnt%0d v%b tag%0d want=cnt1 v1 tag7", count, out_valid, out_tag); end
      tick();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL latency_drain got=%0d want=0", count); end
`endif
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_push(6'(20 + i), 64'(200 + i), 4'b0000);
         #1;
`ifdef MULT_RB_BYPASS_EN
         total++;
         if ({out_valid, out_tag} !== {1'b1, 6'(20 + i)}) begin bad++; $display("FAIL b2b_bypass got=v%b tag%0d want=v1 tag%0d", out_valid, out_tag, 20 + i); end
`else
         total++;
         if (i == 0) begin
            if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_first got=%b want=0", out_valid); end
         end else if ({out_valid, out_tag} !== {1'b1, 6'(19 + i)}) begin
            bad++; $display("FAIL b2b_stream got=v%b tag%0d want=v1 tag%0d", out_valid, out_tag, 19 + i);
         end
`endif
         tick();
      end
      idle();
      tick();
      tick();
      total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_drain got=%0d want=0", count); end
      out_ready = 1'b0;
   endtask

   initial begin
      idle();
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_full();
      test_squash();
      test_clear_incoming();
      test_squash_incoming();
      test_latency();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
